// File: rtl/word_block_fifo.sv
// Packs WSIZE words (first word in the MSBs) into RATIO-word blocks held in a DEPTH-entry first-word-fall-through FIFO; a block is visible 1 cycle after its last word.
// word_ready stalls only when the completing word would overflow a full FIFO or a flush is pending; `WORD_BLOCK_FIFO_FLUSH_EN enables partial-block flush.
module word_block_fifo #(
  parameter int WSIZE = 32,
  parameter int RATIO = 4,
  parameter int DEPTH = 8,
  localparam int BSIZE = WSIZE * RATIO,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(RATIO) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WSIZE-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [BSIZE-1:0] block_out,
  output logic             block_valid,
  input  logic             block_ready,
  input  logic             flush,
  output logic [CW-1:0]    block_words,
  output logic [AW:0]      level,
  output logic             fifo_full,
  output logic             fifo_empty
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [BSIZE-1:0] asm_q, asm_d, asm_next;
  logic             flush_pending_q, flush_pending_d;
  logic [BSIZE-1:0] mem_q [DEPTH];
  logic             word_xfer, block_xfer, last_word, push;
  logic [BSIZE-1:0] push_dat;

  assign level       = wr_ptr_q - rd_ptr_q;
  assign fifo_full   = (level == (AW+1)'(DEPTH));
  assign fifo_empty  = (level == '0);
  assign block_valid = !fifo_empty;
  assign last_word   = (fill_q == CW'(RATIO - 1));
  assign word_ready  = (!last_word || !fifo_full) && !flush_pending_q;
  assign word_xfer   = word_valid && word_ready;
  assign block_xfer  = block_valid && block_ready;
  assign block_out   = block_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

`ifdef WORD_BLOCK_FIFO_FLUSH_EN
  logic [CW-1:0] words_q [DEPTH];
  logic [CW-1:0] push_words;
  assign block_words = block_valid ? words_q[rd_ptr_q[AW-1:0]] : '0;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign block_words  = block_valid ? CW'(RATIO) : '0;
`endif

  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (word_xfer && fill_q == CW'(i)) asm_next[BSIZE-1-i*WSIZE -: WSIZE] = word_in;
    end
    fill_d          = fill_q;
    asm_d           = asm_q;
    flush_pending_d = flush_pending_q;
    push            = 1'b0;
    push_dat        = asm_next;
`ifdef WORD_BLOCK_FIFO_FLUSH_EN
    push_words      = CW'(RATIO);
`endif
    if (word_xfer) begin
      if (last_word) begin
        push   = 1'b1;
        fill_d = '0;
        asm_d  = '0;
      end else begin
        fill_d = fill_q + CW'(1);
        asm_d  = asm_next;
      end
    end
`ifdef WORD_BLOCK_FIFO_FLUSH_EN
    // A pending flush blocks new words, so it never competes with a full-block push.
    if (flush_pending_q) begin
      if (!fifo_full) begin
        push            = 1'b1;
        push_dat        = asm_q;
        push_words      = fill_q;
        fill_d          = '0;
        asm_d           = '0;
        flush_pending_d = 1'b0;
      end
    end else if (flush && fill_d != '0) begin
      flush_pending_d = 1'b1;
    end
`endif
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, block_xfer};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fill_q          <= '0;
      asm_q           <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fill_q          <= fill_d;
      asm_q           <= asm_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q[AW-1:0]]   <= push_dat;
`ifdef WORD_BLOCK_FIFO_FLUSH_EN
      words_q[wr_ptr_q[AW-1:0]] <= push_words;
`endif
    end
  end

endmodule

// File: tb/tb_word_block_fifo.sv
// Randomized and directed bench for word_block_fifo against a queue-based block model.
module tb_word_block_fifo;
  localparam int W = 32, R = 4, D = 8, B = W * R;

  logic          clock = 1'b0;
  logic          reset, word_valid, word_ready, block_valid, block_ready, flush;
  logic [W-1:0]  word_in;
  logic [B-1:0]  block_out;
  logic [2:0]    block_words;
  logic [3:0]    level;
  logic          fifo_full, fifo_empty;

  word_block_fifo #(.WSIZE(W), .RATIO(R), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .block_out(block_out), .block_valid(block_valid),
    .block_ready(block_ready), .flush(flush), .block_words(block_words),
    .level(level), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 clock = ~clock;

  typedef struct { logic [B-1:0] d; int n; } blk_t;
  blk_t         q[$];
  logic [W-1:0] cur[$];
  bit           pend, known;
  int           checks, errors;

  task automatic check(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return (cur.size() < R - 1 || q.size() < D) && !pend;
  endfunction

  function automatic blk_t pack_cur();
    blk_t b;
    b.n = cur.size();
    b.d = '0;
    for (int i = 0; i < R; i++) b.d = (b.d << W) | B'(i < cur.size() ? cur[i] : 32'h0);
    return b;
  endfunction

  task automatic compare_all();
    bit v;
    v = q.size() > 0;
    check("word_ready", B'(word_ready), B'(m_ready()));
    check("block_valid", B'(block_valid), B'(v));
    check("block_out", block_out, v ? q[0].d : '0);
    check("block_words", B'(block_words), v ? B'(q[0].n) : '0);
    check("level", B'(level), B'(q.size()));
    check("fifo_full", B'(fifo_full), B'(q.size() == D));
    check("fifo_empty", B'(fifo_empty), B'(q.size() == 0));
  endtask

  task automatic model_step(input bit wv, input logic [W-1:0] w, input bit br, input bit fl, input bit rst);
    blk_t nb;
    bit   have_new, full_pre, pop;
    if (rst) begin
      q.delete(); cur.delete(); pend = 0; known = 1;
    end else begin
      full_pre = (q.size() == D);
      pop      = q.size() > 0 && br;
      have_new = 0;
      if (wv && m_ready()) begin
        cur.push_back(w);
        if (cur.size() == R) begin nb = pack_cur(); have_new = 1; cur.delete(); end
      end
`ifdef WORD_BLOCK_FIFO_FLUSH_EN
      if (pend) begin
        if (!full_pre) begin nb = pack_cur(); have_new = 1; cur.delete(); pend = 0; end
      end else if (fl && cur.size() > 0) begin
        pend = 1;
      end
`else
      if (fl) have_new = have_new;
`endif
      if (pop) void'(q.pop_front());
      if (have_new) q.push_back(nb);
    end
  endtask

  // One clock cycle: drive inputs, check outputs on the falling edge, advance the model with the edge.
  task automatic step(input bit wv, input logic [W-1:0] w, input bit br, input bit fl, input bit rst);
    word_valid = wv; word_in = w; block_ready = br; flush = fl; reset = rst;
    @(negedge clock);
    if (known) compare_all();
    model_step(wv, w, br, fl, rst);
    @(posedge clock);
    #1;
  endtask

  task automatic push_n(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) step(1, base + W'(i), 0, 0, 0);
  endtask

  initial begin
    checks = 0; errors = 0; known = 0; pend = 0;
    word_valid = 0; word_in = '0; block_ready = 0; flush = 0; reset = 1;
    @(posedge clock); #1;
    step(0, 0, 0, 0, 1);
    check("rst_level", B'(level), '0);
    check("rst_empty", B'(fifo_empty), B'(1));
    check("rst_full", B'(fifo_full), '0);
    check("rst_valid", B'(block_valid), '0);
    check("rst_out", block_out, '0);
    check("rst_words", B'(block_words), '0);
    check("rst_wready", B'(word_ready), B'(1));

    step(1, 32'h11111111, 0, 0, 0);
    step(1, 32'h22222222, 0, 0, 0);
    step(1, 32'h33333333, 0, 0, 0);
    step(1, 32'h44444444, 0, 0, 0);
    check("blk_valid", B'(block_valid), B'(1));
    check("blk_out", block_out, 128'h11111111222222223333333344444444);
    check("blk_words", B'(block_words), B'(4));
    check("blk_level", B'(level), B'(1));

    step(0, 0, 0, 0, 1);
    push_n(32, 32'h1000);
    check("full_level", B'(level), B'(8));
    check("full_flag", B'(fifo_full), B'(1));
    push_n(3, 32'h2000);
    check("full_wready_low", B'(word_ready), '0);
    step(0, 0, 1, 0, 0);
    check("pop_wready", B'(word_ready), B'(1));
    check("pop_level", B'(level), B'(7));
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);

    step(0, 0, 0, 0, 1);
    push_n(6, 32'h3000);
    step(0, 0, 0, 0, 1);
    push_n(4, 32'h4000);
    check("rst_mid_level", B'(level), B'(1));
    check("rst_mid_out", block_out, {32'h4000, 32'h4001, 32'h4002, 32'h4003});
    step(0, 0, 1, 0, 0);
    check("rst_mid_drain", B'(level), '0);

`ifdef WORD_BLOCK_FIFO_FLUSH_EN
    step(0, 0, 0, 0, 1);
    step(1, 32'hAAAAAAAA, 0, 0, 0);
    step(1, 32'hBBBBBBBB, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("flush_out", block_out, 128'hAAAAAAAABBBBBBBB0000000000000000);
    check("flush_words", B'(block_words), B'(2));
    push_n(4, 32'h5000);
    check("flush_next_level", B'(level), B'(2));

    step(0, 0, 0, 0, 1);
    push_n(32, 32'h6000);
    step(1, 32'h7000, 0, 1, 0);
    check("pend_wready", B'(word_ready), '0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("pend_level", B'(level), B'(8));
    check("pend_wready_back", B'(word_ready), B'(1));
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0);
    check("pend_tail_empty", B'(fifo_empty), B'(1));
`endif

    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      step(1, $urandom, 1, 0, 0);
      check("stream_level_le2", B'(level <= 2), B'(1));
    end

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
